// File: rtl/mult_div_seq.sv
// rtl/mult_div_seq.sv - bit-serial multiply / restoring divide sequencer driving HI/LO
// Optional feature macro: MULT_DIV_SEQ_DIV0_EXC_EN (divide-by-zero short-circuit + div_zero flag)
module mult_div_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             div_zero
);

   localparam int CW = $clog2(WIDTH);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_PREP = 3'd1;
   localparam logic [2:0] S_RUN  = 3'd2;
   localparam logic [2:0] S_FIX  = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

   logic [2:0]         state_q, state_d;
   logic [1:0]         op_q, op_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   // multiplicand for multiply, divisor for divide
   logic [WIDTH-1:0]   opnd_q, opnd_d;
   // multiply: {upper partial product, remaining multiplier}; divide: {remainder, quotient}
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               neg_res_q, neg_res_d;
   logic               neg_rem_q, neg_rem_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               done_q, done_d;
`ifdef MULT_DIV_SEQ_DIV0_EXC_EN
   logic               dz_flag_q, dz_flag_d;
   logic               dz_q, dz_d;
`endif

   logic               is_div;
   logic               is_signed;
   logic [WIDTH-1:0]   a_abs;
   logic [WIDTH-1:0]   b_abs;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_shift;
   logic [WIDTH:0]     div_trial;
   logic [2*WIDTH-1:0] mul_step;
   logic [2*WIDTH-1:0] div_step;
   logic [2*WIDTH-1:0] prod_neg;
   logic [WIDTH-1:0]   quo_neg;
   logic [WIDTH-1:0]   rem_neg;

   assign is_div    = op_q[1];
   assign is_signed = ~op_q[0];

   // Datapath helpers: operand magnitudes and one iteration of each algorithm
   always_comb begin
      a_abs     = (is_signed && a_q[WIDTH-1]) ? -a_q : a_q;
      b_abs     = (is_signed && b_q[WIDTH-1]) ? -b_q : b_q;

      // shift-add: conditionally add multiplicand to upper half, keep carry, shift right
      mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
      mul_step  = {mul_sum, acc_q[WIDTH-1:1]};

      // restoring: shifted remainder is WIDTH+1 bits, bit WIDTH of the trial is the borrow
      div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      div_trial = div_shift - {1'b0, opnd_q};
      if (!div_trial[WIDTH]) begin
         div_step = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      end else begin
         div_step = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      end

      prod_neg  = -acc_q;
      quo_neg   = -acc_q[WIDTH-1:0];
      rem_neg   = -acc_q[2*WIDTH-1:WIDTH];
   end

   // Next-state logic for the IDLE/PREP/RUN/FIX/DONE sequence
   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      a_d       = a_q;
      b_d       = b_q;
      opnd_d    = opnd_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      done_d    = (state_q == S_DONE);
`ifdef MULT_DIV_SEQ_DIV0_EXC_EN
      dz_flag_d = dz_flag_q;
      dz_d      = (state_q == S_DONE) && dz_flag_q;
`endif

      case (state_q)
         S_IDLE, S_DONE: begin
            state_d = S_IDLE;
            if (start) begin
               op_d      = op;
               a_d       = a;
               b_d       = b;
               state_d   = S_PREP;
`ifdef MULT_DIV_SEQ_DIV0_EXC_EN
               dz_flag_d = 1'b0;
`endif
            end
         end

         S_PREP: begin
            neg_res_d = is_signed && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
            neg_rem_d = is_signed && a_q[WIDTH-1];
            if (is_div) begin
               acc_d  = {{WIDTH{1'b0}}, a_abs};
               opnd_d = b_abs;
            end else begin
               acc_d  = {{WIDTH{1'b0}}, b_abs};
               opnd_d = a_abs;
            end
            cnt_d   = '0;
            state_d = S_RUN;
`ifdef MULT_DIV_SEQ_DIV0_EXC_EN
            // divide by zero skips the iterations; hi/lo stay as they were
            if (is_div && (b_q == '0)) begin
               dz_flag_d = 1'b1;
               state_d   = S_DONE;
            end
`endif
         end

         S_RUN: begin
            acc_d = is_div ? div_step : mul_step;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
               state_d = S_FIX;
            end
         end

         S_FIX: begin
            if (is_div) begin
               // truncating division: remainder follows the dividend sign
               lo_d = neg_res_q ? quo_neg : acc_q[WIDTH-1:0];
               hi_d = neg_rem_q ? rem_neg : acc_q[2*WIDTH-1:WIDTH];
            end else begin
               lo_d = neg_res_q ? prod_neg[WIDTH-1:0]       : acc_q[WIDTH-1:0];
               hi_d = neg_res_q ? prod_neg[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
            end
            state_d = S_DONE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State registers with synchronous active-high reset
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= S_IDLE;
         op_q      <= '0;
         a_q       <= '0;
         b_q       <= '0;
         opnd_q    <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
         done_q    <= 1'b0;
`ifdef MULT_DIV_SEQ_DIV0_EXC_EN
         dz_flag_q <= 1'b0;
         dz_q      <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         a_q       <= a_d;
         b_q       <= b_d;
         opnd_q    <= opnd_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         done_q    <= done_d;
`ifdef MULT_DIV_SEQ_DIV0_EXC_EN
         dz_flag_q <= dz_flag_d;
         dz_q      <= dz_d;
`endif
      end
   end

   assign busy = (state_q == S_PREP) || (state_q == S_RUN) || (state_q == S_FIX);
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;
`ifdef MULT_DIV_SEQ_DIV0_EXC_EN
   assign div_zero = dz_q;
`else
   assign div_zero = 1'b0;
`endif

endmodule

// File: tb/tb_mult_div_seq.sv
// tb/tb_mult_div_seq.sv - directed self-checking bench for mult_div_seq
module tb_mult_div_seq;

   logic        clock = 1'b0;
   logic        reset;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        div_zero;

   int total = 0;
   int bad   = 0;

   mult_div_seq #(.WIDTH(32)) dut (
      .clock    (clock),
      .reset    (reset),
      .start    (start),
      .op       (op),
      .a        (a),
      .b        (b),
      .busy     (busy),
      .done     (done),
      .hi       (hi),
      .lo       (lo),
      .div_zero (div_zero)
   );

   always #5 clock = ~clock;

   // Drive a start pulse; returns #1 after the edge that sampled it, with inputs scrambled
   task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      op = o; a = x; b = y; start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      a = $urandom; b = $urandom; op = 2'($urandom_range(0, 3));
   endtask

   // Count edges until done (bounded); edges = -1 on timeout
   task automatic wait_done(output int edges, output int busy_cycles);
      edges = 0; busy_cycles = 0;
      while (done !== 1'b1 && edges < 100) begin
         if (busy === 1'b1) busy_cycles++;
         @(posedge clock); #1;
         edges++;
      end
      if (done !== 1'b1) edges = -1;
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
      repeat (3) @(posedge clock);
      #1;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
      total++; if (hi !== 32'h0) begin bad++; $display("FAIL reset_hi got=%h want=0", hi); end
      total++; if (lo !== 32'h0) begin bad++; $display("FAIL reset_lo got=%h want=0", lo); end
      total++; if (div_zero !== 1'b0) begin bad++; $display("FAIL reset_div_zero got=%b want=0", div_zero); end
      reset = 1'b0;
      @(posedge clock); #1;
   endtask

   task automatic test_multu_max();
      int e, bc;
      launch(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_done(e, bc);
      total++; if (e !== 35) begin bad++; $display("FAIL multu_latency got=%0d want=35", e); end
      total++; if (bc !== 34) begin bad++; $display("FAIL multu_busy_cycles got=%0d want=34", bc); end
      total++; if (hi !== 32'hFFFF_FFFE) begin bad++; $display("FAIL multu_hi got=%h want=fffffffe", hi); end
      total++; if (lo !== 32'h0000_0001) begin bad++; $display("FAIL multu_lo got=%h want=00000001", lo); end
      total++; if (div_zero !== 1'b0) begin bad++; $display("FAIL multu_div_zero got=%b want=0", div_zero); end
      @(posedge clock); #1;
      total++; if (done !== 1'b0) begin bad++; $display("FAIL multu_done_pulse got=%b want=0", done); end
   endtask

   task automatic test_back_to_back();
      int e, bc, n;
      launch(2'b00, 32'hFFFF_FFFD, 32'd7);
      total++; if (hi !== 32'hFFFF_FFFE || lo !== 32'h1) begin bad++; $display("FAIL mult_hold_prior got=%h_%h want=fffffffe_00000001", hi, lo); end
      repeat (10) begin @(posedge clock); #1; end
      total++; if (hi !== 32'hFFFF_FFFE || lo !== 32'h1) begin bad++; $display("FAIL mult_hold_mid got=%h_%h want=fffffffe_00000001", hi, lo); end
      n = 0;
      while (busy === 1'b1 && n < 100) begin @(posedge clock); #1; n++; end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_busy_drop got=%b want=0", busy); end
      // busy just dropped: the unit is in DONE; start a divide right here
      op = 2'b10; a = 32'hFFFF_FFF9; b = 32'd2; start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0; a = $urandom; b = $urandom;
      total++; if (done !== 1'b1) begin bad++; $display("FAIL b2b_done_pulse got=%b want=1", done); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_accept got=%b want=1", busy); end
      total++; if (hi !== 32'hFFFF_FFFF) begin bad++; $display("FAIL mult_hi got=%h want=ffffffff", hi); end
      total++; if (lo !== 32'hFFFF_FFEB) begin bad++; $display("FAIL mult_lo got=%h want=ffffffeb", lo); end
      @(posedge clock); #1;
      wait_done(e, bc);
      total++; if (e !== 34) begin bad++; $display("FAIL div_latency got=%0d want=34", e); end
      total++; if (lo !== 32'hFFFF_FFFD) begin bad++; $display("FAIL div_lo got=%h want=fffffffd", lo); end
      total++; if (hi !== 32'hFFFF_FFFF) begin bad++; $display("FAIL div_hi got=%h want=ffffffff", hi); end
      @(posedge clock); #1;
   endtask

   task automatic test_divu();
      int e, bc;
      launch(2'b11, 32'd100, 32'd7);
      wait_done(e, bc);
      total++; if (e !== 35) begin bad++; $display("FAIL divu_latency got=%0d want=35", e); end
      total++; if (lo !== 32'd14) begin bad++; $display("FAIL divu_lo got=%h want=0000000e", lo); end
      total++; if (hi !== 32'd2) begin bad++; $display("FAIL divu_hi got=%h want=00000002", hi); end
      @(posedge clock); #1;
   endtask

   task automatic test_div_zero();
      int e, bc;
      launch(2'b11, 32'd9, 32'd0);
      wait_done(e, bc);
`ifdef MULT_DIV_SEQ_DIV0_EXC_EN
      total++; if (e !== 2) begin bad++; $display("FAIL div0_latency got=%0d want=2", e); end
      total++; if (div_zero !== 1'b1) begin bad++; $display("FAIL div0_flag got=%b want=1", div_zero); end
      total++; if (lo !== 32'd14) begin bad++; $display("FAIL div0_lo_kept got=%h want=0000000e", lo); end
      total++; if (hi !== 32'd2) begin bad++; $display("FAIL div0_hi_kept got=%h want=00000002", hi); end
      @(posedge clock); #1;
      total++; if (div_zero !== 1'b0) begin bad++; $display("FAIL div0_flag_pulse got=%b want=0", div_zero); end
`else
      total++; if (e !== 35) begin bad++; $display("FAIL div0_latency got=%0d want=35", e); end
      total++; if (div_zero !== 1'b0) begin bad++; $display("FAIL div0_flag got=%b want=0", div_zero); end
      total++; if (lo !== 32'hFFFF_FFFF) begin bad++; $display("FAIL div0_lo got=%h want=ffffffff", lo); end
      total++; if (hi !== 32'd9) begin bad++; $display("FAIL div0_hi got=%h want=00000009", hi); end
      @(posedge clock); #1;
`endif
   endtask

   task automatic test_div_overflow();
      int e, bc, seen;
      launch(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
      repeat (5) begin @(posedge clock); #1; end
      // stray start while in RUN must be ignored
      op = 2'b01; a = 32'd3; b = 32'd3; start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      wait_done(e, bc);
      total++; if (e !== 29) begin bad++; $display("FAIL ovf_latency got=%0d want=29", e); end
      total++; if (lo !== 32'h8000_0000) begin bad++; $display("FAIL ovf_lo got=%h want=80000000", lo); end
      total++; if (hi !== 32'h0) begin bad++; $display("FAIL ovf_hi got=%h want=00000000", hi); end
      seen = 0;
      repeat (40) begin @(posedge clock); #1; if (busy === 1'b1 || done === 1'b1) seen++; end
      total++; if (seen !== 0) begin bad++; $display("FAIL ovf_start_ignored got=%0d want=0", seen); end
      total++; if (lo !== 32'h8000_0000 || hi !== 32'h0) begin bad++; $display("FAIL ovf_result_kept got=%h_%h want=00000000_80000000", hi, lo); end
   endtask

   task automatic test_reset_mid();
      int e, bc, seen;
      launch(2'b01, 32'd5, 32'd6);
      repeat (11) begin @(posedge clock); #1; end
      reset = 1'b1;
      @(posedge clock); #1;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b want=0", busy); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL rstmid_done got=%b want=0", done); end
      total++; if (hi !== 32'h0 || lo !== 32'h0) begin bad++; $display("FAIL rstmid_hilo got=%h_%h want=00000000_00000000", hi, lo); end
      reset = 1'b0;
      seen = 0;
      repeat (40) begin @(posedge clock); #1; if (done === 1'b1) seen++; end
      total++; if (seen !== 0) begin bad++; $display("FAIL rstmid_no_done got=%0d want=0", seen); end
      launch(2'b01, 32'd5, 32'd6);
      wait_done(e, bc);
      total++; if (e !== 35) begin bad++; $display("FAIL rerun_latency got=%0d want=35", e); end
      total++; if (lo !== 32'd30) begin bad++; $display("FAIL rerun_lo got=%h want=0000001e", lo); end
      total++; if (hi !== 32'h0) begin bad++; $display("FAIL rerun_hi got=%h want=00000000", hi); end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
      test_reset();
      test_multu_max();
      test_back_to_back();
      test_divu();
      test_div_zero();
      test_div_overflow();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
